// File: rtl/event_counter_timeout.sv
// ============================================================================
// event_counter_timeout: armed event counter with programmable target and
// idle-gap watchdog; one-shot or auto-reload. Optional macro
// EVENT_COUNTER_TIMEOUT_EDGE_EN selects rising-edge event qualification.
// Revision: 1.0
// ============================================================================
`default_nettype none

module event_counter_timeout #(
  parameter int CNT_W       = 8,
  parameter int TMO_W       = 16,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic             pulse,
  input  logic [CNT_W-1:0] target,
  input  logic [TMO_W-1:0] timeout_cycles,
  output logic [CNT_W-1:0] counter,
  output logic             done,
  output logic             timeout,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2,
    S_TMO   = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt_nx, target_q, target_nx, cnt_inc;
  logic [TMO_W-1:0] timer, timer_nx, tmo_q, tmo_nx, timer_inc;
  logic             event_hit;

`ifdef EVENT_COUNTER_TIMEOUT_EDGE_EN
  logic pulse_d;

  // Tracks pulse in every state so a level held across DONE never re-qualifies.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        pulse_d <= 1'b0;
    else if (clear) pulse_d <= 1'b0;
    else            pulse_d <= pulse;
  end

  assign event_hit = pulse & ~pulse_d;
`else
  assign event_hit = pulse;
`endif

  assign cnt_inc   = counter + 1'b1;
  assign timer_inc = timer + 1'b1;

  always_comb begin
    state_nx  = state;
    cnt_nx    = counter;
    timer_nx  = timer;
    target_nx = target_q;
    tmo_nx    = tmo_q;
    if (clear) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
      timer_nx = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            target_nx = target;
            tmo_nx    = timeout_cycles;
            cnt_nx    = '0;
            timer_nx  = '0;
            state_nx  = (target == '0) ? S_DONE : S_COUNT;
          end
        end
        S_COUNT: begin
          // An event wins over a coincident watchdog expiry.
          if (event_hit) begin
            cnt_nx   = cnt_inc;
            timer_nx = '0;
            if (cnt_inc == target_q) state_nx = S_DONE;
          end else begin
            timer_nx = timer_inc;
            if (tmo_q != '0 && timer_inc == tmo_q) state_nx = S_TMO;
          end
        end
        S_DONE: begin
          if (AUTO_RELOAD) begin
            cnt_nx   = '0;
            timer_nx = '0;
            state_nx = S_COUNT;
          end else begin
            state_nx = S_IDLE;
          end
        end
        S_TMO:   state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      counter  <= '0;
      timer    <= '0;
      target_q <= '0;
      tmo_q    <= '0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      counter  <= cnt_nx;
      timer    <= timer_nx;
      target_q <= target_nx;
      tmo_q    <= tmo_nx;
      done     <= (state_nx == S_DONE);
      timeout  <= (state_nx == S_TMO);
      busy     <= (state_nx != S_IDLE);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_event_counter_timeout.sv
// Bench for event_counter_timeout: one-shot and auto-reload instances driven
// together, checked every cycle against a rule-level reference model.
`default_nettype none

module tb_event_counter_timeout;

  logic        clk = 1'b0;
  logic        rst, start, clear, pulse;
  logic [7:0]  target;
  logic [15:0] timeout_cycles;
  logic [7:0]  counter0, counter1;
  logic        done0, done1, timeout0, timeout1, busy0, busy1;

  event_counter_timeout #(.CNT_W(8), .TMO_W(16), .AUTO_RELOAD(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .pulse(pulse),
    .target(target), .timeout_cycles(timeout_cycles),
    .counter(counter0), .done(done0), .timeout(timeout0), .busy(busy0)
  );

  event_counter_timeout #(.CNT_W(8), .TMO_W(16), .AUTO_RELOAD(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .pulse(pulse),
    .target(target), .timeout_cycles(timeout_cycles),
    .counter(counter1), .done(done1), .timeout(timeout1), .busy(busy1)
  );

  always #5 clk = ~clk;

  // Reference: armed = counting, done_now/tmo_now = one-cycle report slots.
  typedef struct {
    bit armed;
    bit done_now;
    bit tmo_now;
    bit pd;
    int cnt;
    int gap;
    int tgt;
    int lim;
  } model_t;

  model_t m0, m1;
  int n_cmp = 0;
  int n_bad = 0;

  function automatic model_t mstep(model_t s, bit ar, bit st, bit clr, bit pl,
                                   int tg, int lm);
    model_t n = s;
    bit q;
`ifdef EVENT_COUNTER_TIMEOUT_EDGE_EN
    q = pl && !s.pd;
`else
    q = pl;
`endif
    n.done_now = 1'b0;
    n.tmo_now  = 1'b0;
    n.pd       = pl;
    if (clr) begin
      n.armed = 1'b0;
      n.cnt   = 0;
      n.gap   = 0;
      n.pd    = 1'b0;
    end else if (s.done_now) begin
      if (ar) begin
        n.armed = 1'b1;
        n.cnt   = 0;
        n.gap   = 0;
      end
    end else if (s.tmo_now) begin
      n.armed = 1'b0;
    end else if (!s.armed) begin
      if (st) begin
        n.tgt = tg;
        n.lim = lm;
        n.cnt = 0;
        n.gap = 0;
        if (tg == 0) n.done_now = 1'b1;
        else         n.armed    = 1'b1;
      end
    end else if (q) begin
      n.cnt = s.cnt + 1;
      n.gap = 0;
      if (n.cnt == s.tgt) begin
        n.armed    = 1'b0;
        n.done_now = 1'b1;
      end
    end else begin
      n.gap = s.gap + 1;
      if (s.lim != 0 && n.gap == s.lim) begin
        n.armed   = 1'b0;
        n.tmo_now = 1'b1;
      end
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("counter0", {24'b0, counter0}, m0.cnt);
    chk("done0",    {31'b0, done0},    {31'b0, m0.done_now});
    chk("timeout0", {31'b0, timeout0}, {31'b0, m0.tmo_now});
    chk("busy0",    {31'b0, busy0},    {31'b0, m0.armed | m0.done_now | m0.tmo_now});
    chk("counter1", {24'b0, counter1}, m1.cnt);
    chk("done1",    {31'b0, done1},    {31'b0, m1.done_now});
    chk("timeout1", {31'b0, timeout1}, {31'b0, m1.tmo_now});
    chk("busy1",    {31'b0, busy1},    {31'b0, m1.armed | m1.done_now | m1.tmo_now});
  endtask

  // Inputs are held from 1ns after the previous edge through this edge.
  task automatic cycle();
    @(posedge clk);
    if (rst) begin
      m0 = '{default: 0};
      m1 = '{default: 0};
    end else begin
      m0 = mstep(m0, 1'b0, start, clear, pulse, int'(target), int'(timeout_cycles));
      m1 = mstep(m1, 1'b1, start, clear, pulse, int'(target), int'(timeout_cycles));
    end
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    start = 1'b0; clear = 1'b0; pulse = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic arm(input int tg, input int lm);
    clear = 1'b1; cycle(); clear = 1'b0;
    target = 8'(tg); timeout_cycles = 16'(lm); start = 1'b1; cycle(); start = 1'b0;
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    m0 = '{default: 0};
    m1 = '{default: 0};
    check_all();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; clear = 1'b0; pulse = 1'b0;
    target = '0; timeout_cycles = '0;
    m0 = '{default: 0};
    m1 = '{default: 0};
    #1 check_all();
    cycle(); cycle();
    rst = 1'b0;
    idle(2);

    // Five spaced pulses to target 5, watchdog off.
    arm(5, 0);
    for (int i = 0; i < 5; i++) begin
      pulse = 1'b1; cycle(); pulse = 1'b0; cycle(); cycle();
    end
    idle(3);

    // Two pulses then silence until the 10-cycle watchdog fires.
    arm(4, 10);
    pulse = 1'b1; cycle(); pulse = 1'b0; cycle();
    pulse = 1'b1; cycle(); pulse = 1'b0;
    idle(14);

    // Events land exactly on the expiry cycle; no timeout may fire.
    arm(20, 3);
    for (int i = 0; i < 10; i++) begin
      cycle(); cycle(); pulse = 1'b1; cycle(); pulse = 1'b0;
    end
    idle(2);

    // Continuous pulse with target 3.
    arm(3, 0);
    pulse = 1'b1;
    for (int i = 0; i < 14; i++) cycle();
    idle(2);

    // Zero target completes immediately.
    arm(0, 0);
    idle(3);

    // Clear in the middle of counting.
    arm(6, 0);
    pulse = 1'b1; cycle(); cycle(); pulse = 1'b0;
    clear = 1'b1; cycle(); clear = 1'b0;
    idle(3);

    // Asynchronous reset mid-count, then a fresh run.
    arm(5, 0);
    pulse = 1'b1; cycle(); cycle(); pulse = 1'b0;
    async_reset();
    idle(1);
    target = 8'd2; timeout_cycles = 16'd0; start = 1'b1; cycle(); start = 1'b0;
    pulse = 1'b1; cycle(); cycle(); pulse = 1'b0;
    idle(4);

    // Randomized traffic with varying pulse density.
    begin
      int dens = 50;
      for (int i = 0; i < 3000; i++) begin
        if (i % 100 == 0) dens = int'($urandom_range(5, 95));
        start          = ($urandom_range(0, 7) == 0);
        clear          = ($urandom_range(0, 59) == 0);
        pulse          = (int'($urandom_range(0, 99)) < dens);
        target         = 8'($urandom_range(0, 6));
        timeout_cycles = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 8));
        if ($urandom_range(0, 699) == 0) begin
          start = 1'b0; clear = 1'b0; pulse = 1'b0;
          async_reset();
        end else begin
          cycle();
        end
      end
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
